// File: rtl/intreq_mux.sv
// intreq_mux: per-level interrupt source mux feeding the BR/BG controller intvec input.
// Define INTMUX_RR_EN for round-robin arbitration instead of fixed priority. Rev 1.0
`default_nettype none

module intreq_mux #(
   parameter int NSRC = 4
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                init_in_h,
   input  logic [NSRC-1:0]     req_in_h,
   input  logic [8*NSRC-1:0]   vec_in_h,
   input  logic                intr_in_h,
   input  logic                ssyn_in_h,
   output logic [7:0]          intvec,
   output logic [NSRC-1:0]     ack_out_h,
   output logic [2:0]          sel_out,
   output logic                busy_out_h
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      XFER  = 2'd2,
      REARM = 2'd3
   } state_t;

   state_t            state, state_n;
   logic [7:0]        intvec_n;
   logic [NSRC-1:0]   ack_n;
   logic [2:0]        sel_n;
   logic [2:0]        win;
   logic [7:0]        win_vec;
   logic [2:0]        start;
   logic              any_req;

   assign any_req = |req_in_h;

`ifdef INTMUX_RR_EN
   logic [2:0] ptr, ptr_n;
   assign start = ptr;
`else
   assign start = 3'd0;
`endif

   // Winner is the requester at the smallest circular distance from start.
   always_comb begin
      int best;
      int d;
      best    = NSRC;
      d       = 0;
      win     = 3'd0;
      win_vec = 8'd1;
      for (int i = 0; i < NSRC; i++) begin
         d = (i - int'(start) + NSRC) % NSRC;
         if (req_in_h[i] && (d < best)) begin
            best    = d;
            win     = 3'(i);
            win_vec = vec_in_h[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_n  = state;
      intvec_n = intvec;
      ack_n    = '0;
      sel_n    = sel_out;
`ifdef INTMUX_RR_EN
      ptr_n    = ptr;
`endif
      case (state)
         IDLE: begin
            intvec_n = 8'd1;
            if (any_req) begin
               sel_n    = win;
               intvec_n = win_vec & 8'hFC;
               state_n  = PEND;
            end
         end
         PEND: begin
            // Commitment by intr takes precedence over a simultaneous request drop.
            if (intr_in_h) begin
               state_n = XFER;
            end else if (!req_in_h[sel_out]) begin
               intvec_n = 8'd1;
               state_n  = IDLE;
            end
         end
         XFER: begin
            if (intr_in_h && ssyn_in_h) begin
               ack_n[sel_out] = 1'b1;
               intvec_n       = 8'd1;
               state_n        = REARM;
`ifdef INTMUX_RR_EN
               ptr_n = (sel_out == 3'(NSRC-1)) ? 3'd0 : sel_out + 3'd1;
`endif
            end else if (!intr_in_h) begin
               intvec_n = 8'd1;
               state_n  = IDLE;
            end
         end
         REARM: begin
            intvec_n = 8'd1;
            state_n  = IDLE;
         end
         default: begin
            intvec_n = 8'd1;
            state_n  = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET || init_in_h) begin
         state      <= IDLE;
         intvec     <= 8'd1;
         ack_out_h  <= '0;
         sel_out    <= 3'd0;
         busy_out_h <= 1'b0;
`ifdef INTMUX_RR_EN
         ptr        <= 3'd0;
`endif
      end else begin
         state      <= state_n;
         intvec     <= intvec_n;
         ack_out_h  <= ack_n;
         sel_out    <= sel_n;
         busy_out_h <= (state_n == PEND) || (state_n == XFER);
`ifdef INTMUX_RR_EN
         ptr        <= ptr_n;
`endif
      end
   end

endmodule

`default_nettype wire

// File: doc/intreq_mux.md
Name: intreq_mux

Overview:
- Per-level interrupt source multiplexer; sits directly upstream of the single-level BR/BG interrupt controller and drives its 8-bit intvec input.
- Collects up to NSRC device interrupt requests that share one BR level. Selects one by priority and presents its vector as a stable intvec (or 1 when idle).
- Tracks the bus vector transfer via the controller's intr/ssyn lines. Pulses a one-clock acknowledge back to the serviced device.

Parameters:
- NSRC, 4, number of request sources (1..8); index 0 is highest fixed priority.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- init_in_h  in  1  bus INIT; same effect as RESET
- req_in_h  in  NSRC  level request per source; held until that source's ack
- vec_in_h  in  8*NSRC  vector per source, source i at bits [8i+7:8i]; bits [1:0] ignored
- intr_in_h  in  1  controller's intr_out_h (vector on bus)
- ssyn_in_h  in  1  bus SSYN
- intvec  out  8  to controller: 8'd1 = no request, else {vec[7:2],2'b00}
- ack_out_h  out  NSRC  one-clock pulse to the serviced source
- sel_out  out  3  index of latched source (valid when busy_out_h)
- busy_out_h  out  1  high in PEND/XFER

Behaviour:
- Reset: RESET or init_in_h (synchronous) forces the following on the next edge, overriding everything:
  - state = IDLE, intvec = 8'd1, ack_out_h = 0, sel_out = 0, busy_out_h = 0.
  - RR pointer (if built) = 0.
- All outputs are registered.
- State IDLE, intvec = 1:
  - If any req_in_h is set, latch the winning index into sel_out.
  - Latch {vec_in_h[sel][7:2],2'b00} into intvec.
  - Go to PEND. Latency from req to intvec valid = 1 clock.
- State PEND:
  - intvec is held from the latched copy; later changes on vec_in_h are ignored.
  - If req_in_h[sel] drops while intr_in_h = 0: intvec = 1 next clock, go to IDLE (cancel), no ack.
  - If intr_in_h = 1: go to XFER (committed). A req drop is ignored from this point.
  - If both the req drop and intr_in_h = 1 occur in the same clock, intr wins and the block goes to XFER.
- State XFER:
  - intvec is held.
  - When intr_in_h & ssyn_in_h: ack_out_h[sel] = 1 for exactly one clock, intvec = 1, go to REARM.
  - If intr_in_h drops without ssyn_in_h: intvec = 1, go to IDLE, no ack.
- State REARM:
  - One clock; intvec = 1; ack_out_h cleared; go to IDLE.
  - Guarantees the serviced source has a clock to drop its req before re-arbitration.
  - Guarantees the controller sees intvec[0] = 1 for at least one clock between transfers.
- Arbitration:
  - Fixed priority, lowest set index wins.
  - Arbitration happens only in IDLE; new requests arriving in PEND/XFER wait.
- Exactly one ack bit can be set at any time; ack never fires on cancel or reset.
- Vector 0 is legal and yields intvec = 8'd0.
- If the requester drops req before intr_in_h, the controller aborts on intvec[0] = 1; the block must never hold a stale vector after cancel.

Optional Feature:
- Macro: INTMUX_RR_EN
- Defined:
  - Round-robin arbitration. A 3-bit pointer holds the index after the last acked source.
  - Search starts at the pointer and wraps modulo NSRC.
  - The pointer updates only on ack, never on cancel.
- Undefined:
  - Fixed priority as above; no pointer register.

Test Plan:
- Single source: NSRC=4, req[2]=1, vec2=8'o240 → next clock intvec=8'o240, busy=1, sel=2. Then intr=1, ssyn=1 → ack[2] pulse one clock, intvec=1, REARM, IDLE.
- Priority: req[1] and req[3] set in the same clock (vec1=8'o060, vec3=8'o070) → intvec=8'o060. After ack[1] and req[1] dropped, two clocks later intvec=8'o070.
- Cancel: req[0] in PEND, drop req[0] before intr → intvec=1 next clock, no ack, IDLE. Repeat with drop in the same clock as intr=1 → XFER, ack on ssyn.
- Vector masking/stability: vec=8'o243 → intvec=8'o240. Changing vec_in_h during XFER leaves intvec unchanged.
- Reset mid-operation: init_in_h=1 in XFER → next clock intvec=1, ack=0, busy=0. RESET behaves identically.
- INTMUX_RR_EN: req[0] and req[1] held continuously with ack-driven service → acks alternate 0,1,0,1. Without the macro → ack[0] only.
